// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame geometry, opcodes and the master state encoding.
// Used by both the master and the slave so the two ends agree on the protocol.
package spi_pkg;

    localparam int CMD_W  = 10;
    localparam int DATA_W = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        LEAD  = 3'b001,
        SHIFT = 3'b010,
        WAIT  = 3'b011,
        RECV  = 3'b100
    } spi_state_t;

endpackage

// File: rtl/spi_shift_cnt.sv
// Loadable down-counter that stops at zero and flags the terminal count.
// A load always wins over a decrement.
module spi_shift_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/spi_master.sv
// SPI master: sends one CMD_W-bit frame per accepted command, MSB first, and for
// read-data commands collects a DATA_W-bit reply after a RD_WAIT-cycle turnaround.
module spi_master #(
    parameter int RD_WAIT = 2,
    parameter int CMD_W   = spi_pkg::CMD_W,
    parameter int DATA_W  = spi_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [CMD_W-1:0]  cmd_data,
    output logic              cmd_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              ss_n,
    output logic              mosi,
    input  logic              miso
);
    import spi_pkg::*;

    localparam int CNT_W = $clog2(CMD_W + DATA_W + RD_WAIT);

    spi_state_t        state;
    logic [CMD_W-1:0]  sh;
    logic [DATA_W-1:0] rx;
    logic              is_read;
    logic              cnt_load;
    logic              cnt_en;
    logic [CNT_W-1:0]  cnt_val;
    logic              tc;

    spi_shift_cnt #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .tc       (tc)
    );

    // The counter is preloaded on entry to each timed phase so that tc marks its last cycle.
    always_comb begin
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_val  = '0;
        case (state)
            LEAD: begin
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(CMD_W - 1);
            end
            SHIFT: begin
                if (tc && is_read) begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(RD_WAIT - 1);
                end else begin
                    cnt_en = 1'b1;
                end
            end
            WAIT: begin
                if (tc) begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(DATA_W - 1);
                end else begin
                    cnt_en = 1'b1;
                end
            end
            RECV:    cnt_en = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ss_n      <= 1'b1;
            mosi      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            sh        <= '0;
            rx        <= '0;
            is_read   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        sh      <= cmd_data;
                        is_read <= (cmd_data[CMD_W-1 -: 2] == OP_RD_DATA);
                        ss_n    <= 1'b0;
                        state   <= LEAD;
                    end
                end
                LEAD: begin
                    mosi  <= sh[CMD_W-1];
                    sh    <= {sh[CMD_W-2:0], 1'b0};
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (!tc) begin
                        mosi <= sh[CMD_W-1];
                        sh   <= {sh[CMD_W-2:0], 1'b0};
                    end else begin
                        mosi <= 1'b0;
                        if (is_read) begin
                            state <= WAIT;
                        end else begin
                            ss_n  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                WAIT: begin
                    if (tc) state <= RECV;
                end
                RECV: begin
                    rx <= {rx[DATA_W-2:0], miso};
                    if (tc) begin
                        rsp_data  <= {rx[DATA_W-2:0], miso};
                        rsp_valid <= 1'b1;
                        ss_n      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    ss_n  <= 1'b1;
                    mosi  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a cycle-indexed frame model checks every output each cycle,
// a small behavioural slave+RAM answers reads, and directed cases pin literal values.
module tb_spi_master;

    localparam int RD_WAIT = 2;
    localparam int LOG_N   = 4096;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic [9:0] cmd_data;
    logic       miso;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       ss_n;
    logic       mosi;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    logic       mosi_log [LOG_N];
    logic       ss_log   [LOG_N];

    logic       f_active = 1'b0;
    int         f_start  = 0;
    logic [9:0] f_cmd    = '0;
    logic       f_read   = 1'b0;
    logic [7:0] f_acc    = '0;
    logic [7:0] rsp_model = '0;

    logic [7:0] sl_mem [256];
    logic [7:0] sl_addr = '0;
    logic [9:0] sl_sh   = '0;
    int         sl_cnt  = 0;
    logic [7:0] sl_byte = '0;
    int         sl_start = -100;

    spi_master #(.RD_WAIT(RD_WAIT), .CMD_W(10), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .ss_n      (ss_n),
        .mosi      (mosi),
        .miso      (miso)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Frame model: expected outputs are a function of the cycle offset from the handshake.
    always @(negedge clk) begin
        int   d;
        logic e_ss, e_mosi, e_busy, e_rv;
        mosi_log[cyc % LOG_N] = mosi;
        ss_log[cyc % LOG_N]   = ss_n;
        e_ss = 1'b1; e_mosi = 1'b0; e_busy = 1'b0; e_rv = 1'b0;
        if (!rst_n) begin
            f_active  = 1'b0;
            rsp_model = '0;
        end else if (f_active) begin
            d = cyc - f_start;
            if (d <= 11) begin
                e_ss = 1'b0; e_busy = 1'b1;
                if (d >= 2) e_mosi = f_cmd[11 - d];
            end else if (f_read && d <= 19 + RD_WAIT) begin
                e_ss = 1'b0; e_busy = 1'b1;
                if (d >= 12 + RD_WAIT) f_acc = {f_acc[6:0], miso};
            end else if (f_read && d == 20 + RD_WAIT) begin
                e_rv      = 1'b1;
                rsp_model = f_acc;
            end
        end
        checkOutput("m_ss_n", ss_n, e_ss);
        checkOutput("m_mosi", mosi, e_mosi);
        checkOutput("m_busy", busy, e_busy);
        checkOutput("m_rsp_valid", rsp_valid, e_rv);
        checkOutput("m_rsp_data", rsp_data, rsp_model);
        if (rst_n) checkOutput("m_cmd_ready", cmd_ready, !e_busy);
        if (rst_n && !e_busy && cmd_valid) begin
            f_active = 1'b1;
            f_start  = cyc;
            f_cmd    = cmd_data;
            f_read   = (cmd_data[9:8] == 2'b11);
            f_acc    = '0;
        end
    end

    // Behavioural slave: skips the lead cycle, decodes 10 bits, answers read-data after RD_WAIT.
    always @(negedge clk) begin
        if (!rst_n || ss_n) begin
            sl_cnt = 0;
        end else begin
            if (sl_cnt >= 1 && sl_cnt <= 10) sl_sh = {sl_sh[8:0], mosi};
            if (sl_cnt == 10) begin
                case (sl_sh[9:8])
                    2'b00: sl_addr = sl_sh[7:0];
                    2'b01: sl_mem[sl_addr] = sl_sh[7:0];
                    2'b10: sl_addr = sl_sh[7:0];
                    2'b11: begin
                        sl_byte  = sl_mem[sl_addr];
                        sl_start = cyc + 1 + RD_WAIT;
                    end
                endcase
            end
            sl_cnt++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (cyc >= sl_start && cyc < sl_start + 8) miso = sl_byte[7 - (cyc - sl_start)];
        else miso = 1'b0;
    end

    task automatic atCycle(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    task automatic waitReady(output int t);
        t = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            checkOutput("ready_timeout", 0, 1);
            t = cyc;
        end
    endtask

    task automatic applyStimulus(input logic [9:0] cmd, output int hs);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_data  = cmd;
        waitReady(hs);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_data  = ~cmd;
    endtask

    function automatic logic [9:0] frameBits(input int t);
        logic [9:0] b = '0;
        for (int k = 2; k <= 11; k++) b = {b[8:0], mosi_log[(t + k) % LOG_N]};
        return b;
    endfunction

    initial begin
        int t, t1, t2;
        rst_n = 1'b1; cmd_valid = 1'b0; cmd_data = '0; miso = 1'b0;
        for (int i = 0; i < 256; i++) sl_mem[i] = 8'h00;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ss_n", ss_n, 1);
        checkOutput("rst_mosi", mosi, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rsp_data", rsp_data, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_ready_after", cmd_ready, 1);

        applyStimulus(10'b00_0011_0101, t);
        atCycle(t + 1);
        checkOutput("wa_ss_lead", ss_n, 0);
        atCycle(t + 12);
        checkOutput("wa_mosi_bits", frameBits(t), 10'b00_0011_0101);
        checkOutput("wa_ss_last", ss_log[(t + 11) % LOG_N], 0);
        checkOutput("wa_ss_end", ss_n, 1);
        checkOutput("wa_ready_end", cmd_ready, 1);

        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_data  = 10'h1FF;
        waitReady(t1);
        @(posedge clk); #1 cmd_data = 10'h235;
        waitReady(t2);
        checkOutput("b2b_gap", t2 - t1, 12);
        checkOutput("b2b_ss_high", ss_n, 1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_ss_low_again", ss_n, 0);
        atCycle(t2 + 12);
        checkOutput("b2b_first_bits", frameBits(t1), 10'h1FF);
        checkOutput("b2b_second_bits", frameBits(t2), 10'h235);

        sl_mem[8'h35] = 8'hA5;
        applyStimulus(10'h300, t);
        atCycle(t + 21);
        checkOutput("rd_no_early_rsp", rsp_valid, 0);
        atCycle(t + 22);
        checkOutput("rd_rsp_valid", rsp_valid, 1);
        checkOutput("rd_rsp_data", rsp_data, 8'hA5);
        checkOutput("rd_ss_high", ss_n, 1);
        atCycle(t + 23);
        checkOutput("rd_rsp_pulse", rsp_valid, 0);
        checkOutput("rd_rsp_held", rsp_data, 8'hA5);

        applyStimulus(10'h1C3, t);
        repeat (3) @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_data  = 10'h0AA;
        @(negedge clk);
        checkOutput("busy_ready_low", cmd_ready, 0);
        @(posedge clk); #1 cmd_valid = 1'b0;
        atCycle(t + 13);
        checkOutput("busy_frame_bits", frameBits(t), 10'h1C3);
        checkOutput("busy_dropped", ss_n, 1);

        applyStimulus(10'h1A5, t);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_ss_n", ss_n, 1);
        checkOutput("mid_rst_mosi", mosi, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_rsp_data", rsp_data, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_ready", cmd_ready, 1);

        applyStimulus(10'h010, t);
        applyStimulus(10'h15C, t);
        applyStimulus(10'h210, t);
        applyStimulus(10'h300, t);
        atCycle(t + 22);
        checkOutput("int_rsp_valid", rsp_valid, 1);
        checkOutput("int_rsp_data", rsp_data, 8'h5C);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog cycle=%0d got=running want=done", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_master.md
# spi_master

Single-clock SPI master that issues 10-bit command frames to the SPI-slave/RAM subsystem and returns 8-bit read data. It accepts commands on a valid/ready interface, drives `ss_n`/`mosi` with one bit per `clk` cycle, and, for read-data commands, samples the slave's `miso` reply after a fixed turnaround. It is the initiator end of the protocol the slave decodes, used by on-chip controllers and as the bench-side driver for slave/RAM integration.

## Interface
- `RD_WAIT`, 2, cycles between last command bit and first sampled `miso` bit (≥1)
- `CMD_W`, 10, command frame width
- `DATA_W`, 8, read-data width
- `clk` in 1: single clock; all logic rising-edge
- `rst_n` in 1: reset, asynchronous, active-low
- `cmd_valid` in 1: command offered
- `cmd_data` in CMD_W: frame; [9:8] opcode (00 write addr, 01 write data, 10 read addr, 11 read data), [7:0] payload
- `cmd_ready` out 1: high only in IDLE; transfer when `cmd_valid & cmd_ready`
- `rsp_valid` out 1: one-cycle pulse, `rsp_data` valid
- `rsp_data` out DATA_W: read byte, held until next response
- `busy` out 1: high in every non-IDLE state
- `ss_n` out 1: slave select, active-low
- `mosi` out 1: serial command, MSB first
- `miso` in 1: serial read data from slave, MSB first

## Operation
- States: IDLE, LEAD, SHIFT, WAIT, RECV.
- IDLE: `ss_n`=1, `mosi`=0, `cmd_ready`=1. On handshake, latch `cmd_data` into shift register, go LEAD.
- LEAD: one cycle, `ss_n`=0, `mosi`=0 (slave IDLE→CHK_CMD step). Go SHIFT, bit counter=9.
- SHIFT: `mosi`=current MSB, shift left each cycle, 10 cycles. After bit 0: opcode 11 → WAIT; else → IDLE.
- WAIT: `ss_n`=0, `mosi`=0 for RD_WAIT cycles, then RECV, counter=7.
- RECV: 8 cycles, sample `miso` on each rising edge into `rsp_data` LSB-side shift register. After 8th sample → IDLE with `rsp_valid`=1 that cycle.
- `cmd_data` changes while busy are ignored; `cmd_valid` in non-IDLE is not accepted.
- Opcode is not otherwise checked; all four opcodes produce valid frames.
- Reset (any time, including mid-frame): state IDLE immediately, `ss_n`=1, `mosi`=0, `cmd_ready`=1 after release, `busy`=0, `rsp_valid`=0, `rsp_data`=0, counters 0. No partial response is emitted.

## Timing
- Handshake at cycle 0 (edge ending cycle 0). Cycle 1: LEAD, `ss_n` falls. Cycles 2–11: `mosi`=cmd_data[9]…[0].
- Non-read frame: cycle 12 IDLE, `ss_n`=1, `cmd_ready`=1; next handshake in cycle 12 gives `ss_n` low again in cycle 13. Minimum one `ss_n`-high cycle between frames always holds.
- Read-data frame: cycles 12..11+RD_WAIT WAIT; `miso` sampled at end of cycles 12+RD_WAIT..19+RD_WAIT (first = bit 7); cycle 20+RD_WAIT IDLE, `rsp_valid`=1, `ss_n`=1. Default: 22 cycles handshake→response.
- All outputs registered; `cmd_ready`/`busy` are state decodes of a registered state.
- `rsp_valid` never coincides with a non-IDLE state.

## Structure
- Shared package `spi_pkg`: opcode constants (OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11), state encoding (IDLE=3'b000, LEAD, SHIFT, WAIT, RECV) and CMD_W/DATA_W defaults, shared with the slave.
- One sub-module natural: `spi_shift_cnt`, a loadable down-counter with terminal-count flag, instantiated for SHIFT/WAIT/RECV counting.
- Everything else in `spi_master`.

## Test plan
- Reset: assert `rst_n`=0 mid-SHIFT of 10'h1A5 → `ss_n`=1, `mosi`=0, `busy`=0 same cycle; no `rsp_valid`; after release `cmd_ready`=1.
- Write addr 10'b00_0011_0101 → `ss_n` low cycles 1–11, `mosi` cycles 2–11 = 0,0,0,0,1,1,0,1,0,1; `ss_n`=1 cycle 12; no `rsp_valid`.
- Back-to-back: write data 10'h1FF then read addr 10'h235 with `cmd_valid` held → second accepted in cycle 12, exactly one `ss_n`-high cycle between frames.
- Read data 10'h300 with bench slave driving 8'hA5 on `miso` from cycle 14 → `rsp_valid` pulse cycle 22, `rsp_data`=8'hA5, `ss_n`=1 same cycle.
- `cmd_valid` pulsed while busy → `cmd_ready`=0, command dropped, frame in flight unaltered.
- Integration with slave+RAM: write addr 8'h10, write data 8'h5C, read addr 8'h10, read data → `rsp_data`=8'h5C.
